// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction fetch stage of the pipeline.
//   Owns the PC, issues requests to the instruction cache, absorbs miss
//   latency and loads the IF/ID register consumed by the decoder.
//
// Ports:
//   CLK          in   system clock, rising edge
//   RST          in   asynchronous active-high reset
//   stall_id     in   hazard unit: hold PC and IF/ID this cycle
//   redirect     in   EX: PC redirect valid (branch, JAL, JALR, mret)
//   redirect_pc  in   EX: redirect target, bits[1:0] forced to zero
//   ic_req       out  cache request valid
//   ic_addr      out  cache fetch address (always the current PC)
//   ic_ready     in   cache: ic_data valid this cycle
//   ic_data      in   cache instruction word
//   if_id_ir     out  IF/ID instruction word
//   if_id_pc     out  IF/ID PC of that instruction
//   if_id_valid  out  IF/ID holds a real instruction
//   fetch_busy   out  high whenever the fetch FSM is not in FETCH
module if_fetch_stage #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        stall_id,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        ic_req,
    output logic [31:0] ic_addr,
    input  logic        ic_ready,
    input  logic [31:0] ic_data,
    output logic [31:0] if_id_ir,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid,
    output logic        fetch_busy
);

    localparam logic [1:0] ST_FETCH   = 2'd0;
    localparam logic [1:0] ST_MISS    = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic        vld_q, vld_d;

    logic        bubble;
    logic        load;
    logic [31:0] load_word;
    logic [31:0] tgt;

    assign tgt = {redirect_pc[31:2], 2'b00};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        buf_d     = buf_q;
        ir_d      = ir_q;
        ifpc_d    = ifpc_q;
        vld_d     = vld_q;
        bubble    = 1'b0;
        load      = 1'b0;
        load_word = ic_data;

        case (state_q)
            ST_FETCH: begin
                if (redirect) begin
                    bubble = 1'b1;
                    pc_d   = tgt;
                end else if (ic_ready) begin
                    // Under stall nothing moves: the same address is re-presented.
                    if (!stall_id) load = 1'b1;
                end else begin
                    state_d = ST_MISS;
                    if (!stall_id) bubble = 1'b1;
                end
            end
            ST_MISS: begin
                if (redirect) begin
                    bubble = 1'b1;
                    if (ic_ready) begin
                        pc_d    = tgt;
                        state_d = ST_FETCH;
                    end else begin
                        // Fill cannot be aborted; remember the target and
                        // keep the old address up until the fill drains.
                        pend_pc_d = tgt;
                        state_d   = ST_DISCARD;
                    end
                end else if (ic_ready) begin
                    if (!stall_id) begin
                        load    = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        // Fill data is delivered only once; park it.
                        buf_d   = ic_data;
                        state_d = ST_HOLD;
                    end
                end else if (!stall_id) begin
                    bubble = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    bubble  = 1'b1;
                    pc_d    = tgt;
                    state_d = ST_FETCH;
                end else if (!stall_id) begin
                    load      = 1'b1;
                    load_word = buf_q;
                    state_d   = ST_FETCH;
                end
            end
            ST_DISCARD: begin
                bubble = 1'b1;
                if (redirect) pend_pc_d = tgt;
                if (ic_ready) begin
                    // Latest redirect wins, including one arriving this cycle.
                    pc_d    = redirect ? tgt : pend_pc_q;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase

        if (bubble) begin
            ir_d   = NOP_INSTR;
            ifpc_d = pc_q;
            vld_d  = 1'b0;
        end
        if (load) begin
            ir_d   = load_word;
            ifpc_d = pc_q;
            vld_d  = 1'b1;
            pc_d   = pc_q + 32'd4;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_VEC;
            pend_pc_q <= 32'd0;
            buf_q     <= 32'd0;
            ir_q      <= NOP_INSTR;
            ifpc_q    <= 32'd0;
            vld_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            buf_q     <= buf_d;
            ir_q      <= ir_d;
            ifpc_q    <= ifpc_d;
            vld_q     <= vld_d;
        end
    end

    assign ic_req      = !RST && (state_q != ST_HOLD);
    assign ic_addr     = pc_q;
    assign if_id_ir    = ir_q;
    assign if_id_pc    = ifpc_q;
    assign if_id_valid = vld_q;
    assign fetch_busy  = (state_q != ST_FETCH);

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST;
    logic        stall_id;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_ready;
    logic [31:0] ic_data;
    logic [31:0] if_id_ir;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
    logic        fetch_busy;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 CLK = ~CLK;

    if_fetch_stage #(
        .RESET_VEC(32'h0000_0000),
        .NOP_INSTR(NOP)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .stall_id(stall_id),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .ic_req(ic_req),
        .ic_addr(ic_addr),
        .ic_ready(ic_ready),
        .ic_data(ic_data),
        .if_id_ir(if_id_ir),
        .if_id_pc(if_id_pc),
        .if_id_valid(if_id_valid),
        .fetch_busy(fetch_busy)
    );

    // Memory content: each address maps to a distinct non-NOP word.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {8'hE5, a[23:0]};
    endfunction

    assign ic_data = word_of(ic_addr);

    // ------------------------------------------------------------------
    // Reference model: tracks the architectural fetch situation.
    //   m_pc       next address to fetch
    //   m_waiting  a fill is outstanding for m_pc
    //   m_parked   a fill word arrived during a stall and waits in m_word
    //   m_dropping an outstanding fill must be thrown away, then go to m_tgt
    // ------------------------------------------------------------------
    logic [31:0] m_pc, m_word, m_tgt, m_ir, m_ifpc;
    bit          m_waiting, m_parked, m_dropping, m_vld;

    task automatic model_reset();
        m_pc = 32'h0; m_word = 32'h0; m_tgt = 32'h0;
        m_ir = NOP; m_ifpc = 32'h0; m_vld = 1'b0;
        m_waiting = 1'b0; m_parked = 1'b0; m_dropping = 1'b0;
    endtask

    task automatic m_bubble();
        m_ir = NOP; m_ifpc = m_pc; m_vld = 1'b0;
    endtask

    task automatic m_issue(input logic [31:0] w);
        m_ir = w; m_ifpc = m_pc; m_vld = 1'b1; m_pc = m_pc + 32'd4;
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        logic [31:0] t;
        t = redirect_pc & 32'hFFFF_FFFC;
        if (m_dropping) begin
            m_bubble();
            if (redirect) m_tgt = t;
            if (ic_ready) begin
                m_pc = m_tgt;
                m_dropping = 1'b0;
            end
        end else if (redirect) begin
            m_bubble();
            if (m_waiting && !ic_ready) begin
                m_dropping = 1'b1;
                m_tgt = t;
            end else begin
                m_pc = t;
            end
            m_waiting = 1'b0;
            m_parked  = 1'b0;
        end else if (m_parked) begin
            if (!stall_id) begin
                m_issue(m_word);
                m_parked = 1'b0;
            end
        end else if (ic_ready) begin
            if (stall_id) begin
                if (m_waiting) begin
                    m_word = word_of(m_pc);
                    m_parked = 1'b1;
                end
            end else begin
                m_issue(word_of(m_pc));
            end
            m_waiting = 1'b0;
        end else begin
            m_waiting = 1'b1;
            if (!stall_id) m_bubble();
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge CLK) begin
        if (chk_en && !RST) begin
            chk("m_ic_req", {31'd0, ic_req}, {31'd0, !m_parked});
            chk("m_ic_addr", ic_addr, m_pc);
            chk("m_ir", if_id_ir, m_ir);
            chk("m_ifpc", if_id_pc, m_ifpc);
            chk("m_valid", {31'd0, if_id_valid}, {31'd0, m_vld});
            chk("m_busy", {31'd0, fetch_busy}, {31'd0, m_waiting || m_parked || m_dropping});
        end
    end

    task automatic step(input bit rdy, input bit stl, input bit rd, input logic [31:0] rpc);
        ic_ready = rdy; stall_id = stl; redirect = rd; redirect_pc = rpc;
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, {31'd0, ic_req}, 32'd0);
        chk({tag, "_addr"}, ic_addr, 32'h0);
        chk({tag, "_ir"}, if_id_ir, NOP);
        chk({tag, "_pc"}, if_id_pc, 32'h0);
        chk({tag, "_valid"}, {31'd0, if_id_valid}, 32'd0);
        chk({tag, "_busy"}, {31'd0, fetch_busy}, 32'd0);
    endtask

    initial begin
        RST = 1'b1; stall_id = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; ic_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge CLK);
        chk_reset_outputs("rst");
        RST = 1'b0;
        chk_en = 1'b1;

        // All hits from reset: one instruction per cycle.
        step(1, 0, 0, 0);
        chk("hit0_pc", if_id_pc, 32'h0);
        chk("hit0_valid", {31'd0, if_id_valid}, 32'd1);
        chk("hit0_ir", if_id_ir, 32'hE500_0000);
        step(1, 0, 0, 0); chk("hit1_pc", if_id_pc, 32'h4);
        step(1, 0, 0, 0); chk("hit2_pc", if_id_pc, 32'h8);
        step(1, 0, 0, 0); chk("hit3_pc", if_id_pc, 32'hC);

        // Miss at 0x10 for four cycles.
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0);
            chk("miss_addr", ic_addr, 32'h10);
            chk("miss_ir", if_id_ir, NOP);
        end
        step(1, 0, 0, 0);
        chk("fill_pc", if_id_pc, 32'h10);
        chk("fill_ir", if_id_ir, 32'hE500_0010);
        chk("fill_next", ic_addr, 32'h14);

        // Miss at 0x14, fill arrives under stall, stall held two more cycles.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        chk("hold_req", {31'd0, ic_req}, 32'd0);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("hold_ir", if_id_ir, NOP);
        chk("hold_busy", {31'd0, fetch_busy}, 32'd1);
        step(0, 0, 0, 0);
        chk("unhold_ir", if_id_ir, 32'hE500_0014);
        chk("unhold_next", ic_addr, 32'h18);

        // Redirect to 0x40, miss there, then redirect to 0x200 mid-miss.
        step(1, 0, 1, 32'h40);
        chk("redir40_addr", ic_addr, 32'h40);
        chk("redir40_valid", {31'd0, if_id_valid}, 32'd0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h200);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("discard_addr", ic_addr, 32'h40);
        step(1, 0, 0, 0);
        chk("discard_exit", ic_addr, 32'h200);
        chk("discard_ir", if_id_ir, NOP);
        step(1, 0, 0, 0);
        chk("after_discard_pc", if_id_pc, 32'h200);

        // Redirect with stall in FETCH, then two redirects while discarding.
        step(1, 1, 1, 32'h300);
        chk("rs_addr", ic_addr, 32'h300);
        chk("rs_valid", {31'd0, if_id_valid}, 32'd0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h400);
        step(0, 1, 1, 32'h500);
        step(1, 0, 0, 0);
        chk("latest_wins", ic_addr, 32'h500);

        // Redirect on the very cycle the discarded fill completes.
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h600);
        step(1, 0, 1, 32'h700);
        chk("same_cycle_redir", ic_addr, 32'h700);

        // PC wrap and target alignment.
        step(1, 0, 1, 32'hFFFF_FFFC);
        step(1, 0, 0, 0);
        chk("wrap_addr", ic_addr, 32'h0);
        chk("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
        step(1, 0, 1, 32'h103);
        chk("align_addr", ic_addr, 32'h100);
        step(1, 0, 0, 0);
        chk("align_ir", if_id_ir, 32'hE500_0100);

        // Asynchronous reset in the middle of a miss.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        #2 RST = 1'b1;
        #1;
        chk_reset_outputs("arst");
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
        step(1, 0, 0, 0);
        chk("restart_pc", if_id_pc, 32'h0);
        chk("restart_addr", ic_addr, 32'h4);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
